// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: holds the dynamic 3x16 character image for LCD lines 2-4.
// It accepts single-character writes and binary values. A value is converted to
// ASCII decimal in place by sequential double-dabble. Characters are served to the
// LCD controller through a registered read port, and frame_ready is raised after
// the image changes.
//
// Handshakes: a write transfers on a rising edge where valid && ready are both high.
// The requester holds valid and the payload stable until that edge. wr_ready and
// val_ready depend only on state, plus wr_valid for val_ready, so a character
// write wins when both are requested in the same cycle.
module lcd_text_buffer #(
    parameter int NUM_LINES   = 3,
    parameter int NUM_COLS    = 16,
    parameter int DATA_BITS   = 8,
    parameter int VAL_WIDTH   = 16,
    parameter int DIGITS      = 5,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [1:0]           wr_line,
    input  logic [3:0]           wr_col,
    input  logic [DATA_BITS-1:0] wr_char,
    input  logic                 val_valid,
    output logic                 val_ready,
    input  logic [1:0]           val_line,
    input  logic [3:0]           val_col,
    input  logic [VAL_WIDTH-1:0] val_data,
    input  logic [1:0]           rd_line,
    input  logic [3:0]           rd_col,
    output logic [DATA_BITS-1:0] rd_char,
    output logic                 frame_ready,
    input  logic                 frame_ack
);

    localparam int CELLS = NUM_LINES * NUM_COLS;
    localparam int AW    = $clog2(CELLS);
    localparam int BW    = DIGITS * 4;
    localparam int CW    = $clog2(VAL_WIDTH + 1);

    localparam logic [DATA_BITS-1:0] CH_SPACE = DATA_BITS'(32'h20);
    localparam logic [DATA_BITS-1:0] CH_ZERO  = DATA_BITS'(32'h30);

    localparam logic [1:0] S_CLEAR   = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;
    localparam logic [1:0] S_EMIT    = 2'd3;

    logic [1:0]           state_q,   state_d;
    logic [AW-1:0]        clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]        step_q,    step_d;
    logic [1:0]           line_q,    line_d;
    logic [3:0]           col_q,     col_d;
    logic [VAL_WIDTH-1:0] shift_q,   shift_d;
    logic [BW-1:0]        bcd_q,     bcd_d;
    logic                 seen_q,    seen_d;
    logic                 dirty_q,   dirty_d;
    logic [DATA_BITS-1:0] rd_char_q;

    logic [DATA_BITS-1:0] mem [CELLS];

    logic [BW-1:0]        bcd_adj;
    logic [3:0]           emit_nib;
    logic                 emit_last;
    logic                 emit_blank;
    logic [DATA_BITS-1:0] emit_char;
    int                   emit_col;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic                 set_dirty;

    function automatic logic [AW-1:0] cell_addr(input int line, input int col);
        return AW'(line * NUM_COLS + col);
    endfunction

    assign wr_ready    = (state_q == S_IDLE);
    assign val_ready   = (state_q == S_IDLE) && !wr_valid;
    assign frame_ready = dirty_q && (state_q == S_IDLE);
    assign rd_char     = rd_char_q;

    // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Select the digit for this EMIT step, MSB first, and apply leading-zero blanking.
    always_comb begin
        emit_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_q == CW'(DIGITS - 1 - i)) begin
                emit_nib = bcd_q[i*4 +: 4];
            end
        end
        emit_last  = (step_q == CW'(DIGITS - 1));
        emit_blank = (BLANK_ZEROS != 0) && !seen_q && (emit_nib == 4'd0) && !emit_last;
        emit_char  = emit_blank ? CH_SPACE : CH_ZERO + DATA_BITS'(emit_nib);
        emit_col   = int'(col_q) + int'(step_q);
    end

    // Next-state logic and the single buffer write port, shared by CLEAR, IDLE and EMIT.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        step_d    = step_q;
        line_d    = line_q;
        col_d     = col_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        seen_d    = seen_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        set_dirty = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = CH_SPACE;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(CELLS - 1)) begin
                    state_d   = S_IDLE;
                    set_dirty = 1'b1;
                end
            end
            S_IDLE: begin
                if (wr_valid) begin
                    if (int'(wr_line) < NUM_LINES) begin
                        mem_we    = 1'b1;
                        mem_waddr = cell_addr(int'(wr_line), int'(wr_col));
                        mem_wdata = wr_char;
                        set_dirty = 1'b1;
                    end
                end else if (val_valid) begin
                    line_d  = val_line;
                    col_d   = val_col;
                    shift_d = val_data;
                    bcd_d   = '0;
                    step_d  = '0;
                    seen_d  = 1'b0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d   = BW'({bcd_adj, shift_q[VAL_WIDTH-1]});
                shift_d = {shift_q[VAL_WIDTH-2:0], 1'b0};
                step_d  = step_q + 1'b1;
                if (step_q == CW'(VAL_WIDTH - 1)) begin
                    step_d  = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                // Digits past the last column are dropped rather than wrapped.
                if ((int'(line_q) < NUM_LINES) && (emit_col < NUM_COLS)) begin
                    mem_we    = 1'b1;
                    mem_waddr = cell_addr(int'(line_q), emit_col);
                    mem_wdata = emit_char;
                end
                seen_d = seen_q || (emit_nib != 4'd0);
                step_d = step_q + 1'b1;
                if (emit_last) begin
                    step_d    = '0;
                    state_d   = S_IDLE;
                    set_dirty = (int'(line_q) < NUM_LINES);
                end
            end
            default: state_d = S_CLEAR;
        endcase
        // A set in the same cycle as an ack wins, so no change is lost.
        dirty_d = (dirty_q && !frame_ack) || set_dirty;
    end

    // Control and conversion registers; reset discards any in-flight conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            step_q    <= '0;
            line_q    <= '0;
            col_q     <= '0;
            shift_q   <= '0;
            bcd_q     <= '0;
            seen_q    <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            step_q    <= step_d;
            line_q    <= line_d;
            col_q     <= col_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            seen_q    <= seen_d;
            dirty_q   <= dirty_d;
        end
    end

    // Character storage; CLEAR initialises it, so it has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port; a same-cycle write to the cell returns the old character.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_char_q <= '0;
        end else if (int'(rd_line) < NUM_LINES) begin
            rd_char_q <= mem[cell_addr(int'(rd_line), int'(rd_col))];
        end else begin
            rd_char_q <= '0;
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: table-driven vectors, hand-written corner sequences and
// randomized operations checked against a behavioural model of the character image.
module tb_lcd_text_buffer;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_line = '0;
    logic [3:0]  wr_col = '0;
    logic [7:0]  wr_char = '0;
    logic        val_valid = 1'b0;
    logic        val_ready;
    logic [1:0]  val_line = '0;
    logic [3:0]  val_col = '0;
    logic [15:0] val_data = '0;
    logic [1:0]  rd_line = '0;
    logic [3:0]  rd_col = '0;
    logic [7:0]  rd_char;
    logic        frame_ready;
    logic        frame_ack = 1'b0;

    lcd_text_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_line     (wr_line),
        .wr_col      (wr_col),
        .wr_char     (wr_char),
        .val_valid   (val_valid),
        .val_ready   (val_ready),
        .val_line    (val_line),
        .val_col     (val_col),
        .val_data    (val_data),
        .rd_line     (rd_line),
        .rd_col      (rd_col),
        .rd_char     (rd_char),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [7:0] model_mem [3][16];
    bit         model_dirty;

    typedef struct {
        int kind;     // 0 char write, 1 value write, 2 read only
        bit ack;      // acknowledge the frame before the operation
        int line;
        int col;
        int data;
        int cl;       // cell to read back
        int cc;
        int exp_ch;
        bit exp_fr;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 16; c++)
                model_mem[l][c] = 8'h20;
        model_dirty = 1'b1;
    endtask

    task automatic model_char(input int line, input int col, input logic [7:0] ch);
        if (line < 3 && col < 16) begin
            model_mem[line][col] = ch;
            model_dirty = 1'b1;
        end
    endtask

    task automatic model_value(input int line, input int col, input int val);
        int  p;
        int  d;
        bit  seen;
        logic [7:0] ch;
        if (line >= 3) return;
        p = 10000;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = (val / p) % 10;
            p = p / 10;
            if (!seen && d == 0 && k != 4) ch = 8'h20;
            else ch = 8'(8'h30 + d);
            if (d != 0) seen = 1'b1;
            if (col + k < 16) model_mem[line][col + k] = ch;
        end
        model_dirty = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (wr_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("idle_timeout", wr_ready, 1'b1);
    endtask

    task automatic wait_value_done();
        int n = 0;
        while (val_ready !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("val_busy_cycles", n, 21);
    endtask

    task automatic do_char(input int line, input int col, input logic [7:0] ch);
        wait_idle();
        wr_valid = 1'b1;
        wr_line  = 2'(line);
        wr_col   = 4'(col);
        wr_char  = ch;
        tick();
        wr_valid = 1'b0;
        model_char(line, col, ch);
    endtask

    task automatic do_value(input int line, input int col, input int val);
        wait_idle();
        val_valid = 1'b1;
        val_line  = 2'(line);
        val_col   = 4'(col);
        val_data  = 16'(val);
        tick();
        val_valid = 1'b0;
        wait_value_done();
        model_value(line, col, val);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        model_dirty = 1'b0;
    endtask

    task automatic read_cell(input int line, input int col, output logic [7:0] d);
        rd_line = 2'(line);
        rd_col  = 4'(col);
        tick();
        d = rd_char;
    endtask

    task automatic check_all(input string name);
        logic [7:0] d;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 16; c++) begin
                read_cell(l, c, d);
                check($sformatf("%s_%0d_%0d", name, l, c), d, model_mem[l][c]);
            end
    endtask

    task automatic do_reset();
        int n = 0;
        wr_valid  = 1'b0;
        val_valid = 1'b0;
        frame_ack = 1'b0;
        reset     = 1'b1;
        tick();
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_val_ready", val_ready, 1'b0);
        check("rst_frame_ready", frame_ready, 1'b0);
        check("rst_rd_char", rd_char, 8'h00);
        reset = 1'b0;
        while (wr_ready !== 1'b1 && n < 200) begin
            check("clear_val_ready", val_ready, 1'b0);
            tick();
            n++;
        end
        check("clear_cycles", n, 48);
        model_clear();
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [7:0] d;
        logic [7:0] old;
        int r;
        int line;
        int col;
        int val;

        // Reset and CLEAR.
        do_reset();
        check("clear_frame_ready", frame_ready, 1'b1);
        check_all("clear_cell");

        // Table-driven vectors with hand-derived expectations.
        vq.push_back('{0, 1, 1,  0, 'h41,   1,  0, 'h41, 1});
        vq.push_back('{1, 1, 0,  2, 1234,  0,  2, 'h20, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0,  3, 'h31, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0,  4, 'h32, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0,  5, 'h33, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0,  6, 'h34, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0,  7, 'h20, 1});
        vq.push_back('{1, 1, 2, 13, 65535, 2, 13, 'h36, 1});
        vq.push_back('{2, 0, 0,  0, 0,     2, 14, 'h35, 1});
        vq.push_back('{2, 0, 0,  0, 0,     2, 15, 'h35, 1});
        vq.push_back('{2, 0, 0,  0, 0,     2, 12, 'h20, 1});
        vq.push_back('{1, 1, 1,  8, 0,     1, 12, 'h30, 1});
        vq.push_back('{2, 0, 0,  0, 0,     1,  8, 'h20, 1});
        vq.push_back('{2, 0, 0,  0, 0,     1, 11, 'h20, 1});
        vq.push_back('{2, 0, 0,  0, 0,     1,  0, 'h41, 1});
        vq.push_back('{0, 1, 3,  0, 'h5A,  0,  0, 'h20, 0});
        vq.push_back('{1, 1, 3,  0, 7,     0,  0, 'h20, 0});
        vq.push_back('{0, 1, 0, 15, 'h51,  0, 15, 'h51, 1});
        vq.push_back('{1, 1, 0, 11, 10,    0, 14, 'h31, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0, 15, 'h30, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0, 11, 'h20, 1});
        vq.push_back('{1, 1, 1,  3, 9,     1,  7, 'h39, 1});
        vq.push_back('{1, 1, 0, 14, 65535, 0, 14, 'h36, 1});
        vq.push_back('{2, 0, 0,  0, 0,     0, 15, 'h35, 1});
        vq.push_back('{2, 0, 0,  0, 0,     1,  0, 'h41, 1});
        vq.push_back('{2, 0, 0,  0, 0,     1,  1, 'h20, 1});
        vq.push_back('{2, 0, 0,  0, 0,     1,  2, 'h20, 1});
        vq.push_back('{1, 1, 2,  0, 100,   2,  2, 'h31, 1});
        vq.push_back('{2, 0, 0,  0, 0,     2,  1, 'h20, 1});
        vq.push_back('{2, 0, 0,  0, 0,     2,  4, 'h30, 1});

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].ack) do_ack();
            case (vq[i].kind)
                0: do_char(vq[i].line, vq[i].col, 8'(vq[i].data));
                1: do_value(vq[i].line, vq[i].col, vq[i].data);
                default: ;
            endcase
            check($sformatf("vec%0d_frame_ready", i), frame_ready, vq[i].exp_fr);
            read_cell(vq[i].cl, vq[i].cc, d);
            check($sformatf("vec%0d_cell", i), d, vq[i].exp_ch);
        end

        // Read and write of the same cell in one cycle returns the old character.
        wait_idle();
        old      = model_mem[0][0];
        rd_line  = 2'd0;
        rd_col   = 4'd0;
        wr_valid = 1'b1;
        wr_line  = 2'd0;
        wr_col   = 4'd0;
        wr_char  = 8'h52;
        tick();
        wr_valid = 1'b0;
        model_char(0, 0, 8'h52);
        check("rd_same_cycle_old", rd_char, old);
        tick();
        check("rd_after_write_new", rd_char, 8'h52);

        // Simultaneous requests: the character goes first, the value the next cycle.
        wait_idle();
        wr_valid  = 1'b1;
        wr_line   = 2'd2;
        wr_col    = 4'd5;
        wr_char   = 8'h78;
        val_valid = 1'b1;
        val_line  = 2'd2;
        val_col   = 4'd6;
        val_data  = 16'd42;
        #1;
        check("both_val_ready", val_ready, 1'b0);
        check("both_wr_ready", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        model_char(2, 5, 8'h78);
        #1;
        check("second_val_ready", val_ready, 1'b1);
        tick();
        val_valid = 1'b0;
        wait_value_done();
        model_value(2, 6, 42);
        read_cell(2, 5, d);
        check("both_char", d, 8'h78);
        read_cell(2, 9, d);
        check("both_digit4", d, 8'h34);
        read_cell(2, 10, d);
        check("both_digit2", d, 8'h32);

        // Ack in the same cycle as a write keeps frame_ready high; ack alone clears it.
        wait_idle();
        frame_ack = 1'b1;
        wr_valid  = 1'b1;
        wr_line   = 2'd0;
        wr_col    = 4'd1;
        wr_char   = 8'h6B;
        tick();
        frame_ack = 1'b0;
        wr_valid  = 1'b0;
        model_char(0, 1, 8'h6B);
        check("ack_with_write", frame_ready, 1'b1);
        do_ack();
        check("ack_clears", frame_ready, 1'b0);

        // Randomized operations against the model.
        for (int i = 0; i < 80; i++) begin
            r    = $urandom_range(0, 9);
            line = $urandom_range(0, 3);
            col  = $urandom_range(0, 15);
            if (r <= 3) begin
                do_char(line, col, 8'($urandom_range(32, 126)));
            end else if (r <= 6) begin
                val = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 120);
                do_value(line, col, val);
            end else if (r == 7) begin
                do_ack();
            end else if (line < 3) begin
                read_cell(line, col, d);
                check($sformatf("rand%0d_read", i), d, model_mem[line][col]);
            end
            check($sformatf("rand%0d_frame_ready", i), frame_ready, model_dirty);
        end
        check_all("rand_cell");

        // Reset during a conversion: full CLEAR, no digits appear.
        do_ack();
        wait_idle();
        val_valid = 1'b1;
        val_line  = 2'd1;
        val_col   = 4'd0;
        val_data  = 16'd54321;
        tick();
        val_valid = 1'b0;
        repeat (8) tick();
        do_reset();
        check("midconv_frame_ready", frame_ready, 1'b1);
        check_all("midconv_cell");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
